// File: rtl/usb_transmitter.sv
// rtl/usb_transmitter.sv - USB full-speed packet transmitter (SYNC, data, CRC16, NRZI, bit stuffing, EOP)
//
// Reads packet bytes from a word-wide buffer and serialises them onto D+/D-.
// One raw bit is placed on the line every BIT_CYCLES clk48 cycles.
//
// Ports
//   clk48              : sole clock, posedge
//   reset              : synchronous active-high reset
//   start              : one-cycle transmit request, honoured only while idle
//   start_word_address : buffer word index holding byte 0 (sampled with start)
//   packet_length      : byte count 1..1024 (0 is ignored), sampled with start
//   append_crc         : append CRC16 after the last byte, sampled with start
//   buffer_address     : buffer word index being read
//   buffer_read_value  : word at buffer_address, one cycle of read latency
//   usb_d_p_out        : D+ drive value
//   usb_d_n_out        : D- drive value
//   usb_output_enable  : high while driving the bus
//   busy               : high from accepted start until done
//   done               : one-cycle pulse when the packet is finished
module usb_transmitter #(
  parameter int BIT_CYCLES = 4
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  start_word_address,
  input  logic [10:0] packet_length,
  input  logic        append_crc,
  output logic [7:0]  buffer_address,
  input  logic [31:0] buffer_read_value,
  output logic        usb_d_p_out,
  output logic        usb_d_n_out,
  output logic        usb_output_enable,
  output logic        busy,
  output logic        done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_CRC     = 3'd3;
  localparam logic [2:0] S_EOP_SE0 = 3'd4;
  localparam logic [2:0] S_EOP_J   = 3'd5;

  // The state names the next thing to be put on the line at the coming bit
  // boundary; the line registers hold what is being driven right now.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [10:0]   byte_idx_q, byte_idx_d;
  logic [10:0]   last_byte_q, last_byte_d;
  logic          append_crc_q, append_crc_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   word_q, word_d;
  logic [15:0]   crc_q, crc_d;
  logic [2:0]    ones_q, ones_d;
  logic          line_j_q, line_j_d;
  logic          se0_q, se0_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic          raw_bit;
  logic [15:0]   crc_step;

  assign bit_end = (cyc_q == CW'(BIT_CYCLES - 1));

  // Raw (pre-stuffing, pre-NRZI) bit waiting to be sent.
  always_comb begin
    raw_bit = 1'b0;
    case (state_q)
      S_SYNC:  raw_bit = (bit_idx_q[2:0] == 3'd7);
      S_DATA:  raw_bit = word_q[{byte_idx_q[1:0], bit_idx_q[2:0]}];
      S_CRC:   raw_bit = ~crc_q[0];
      default: raw_bit = 1'b0;
    endcase
  end

  // Reflected form of x^16+x^15+x^2+1, fed LSB first.
  assign crc_step = {1'b0, crc_q[15:1]} ^ ((raw_bit ^ crc_q[0]) ? 16'hA001 : 16'h0000);

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    last_byte_d  = last_byte_q;
    append_crc_d = append_crc_q;
    addr_d       = addr_q;
    word_d       = word_q;
    crc_d        = crc_q;
    ones_d       = ones_q;
    line_j_d     = line_j_q;
    se0_d        = se0_q;
    done_d       = 1'b0;

    if (state_q == S_IDLE) begin
      if (start && (packet_length != 11'd0)) begin
        // The first bit time after acceptance is the idle J lead-in; the
        // first word is addressed now and captured when SYNC finishes.
        state_d      = S_SYNC;
        cyc_d        = '0;
        bit_idx_d    = 4'd0;
        byte_idx_d   = 11'd0;
        last_byte_d  = packet_length - 11'd1;
        append_crc_d = append_crc;
        addr_d       = start_word_address;
        crc_d        = 16'hFFFF;
        ones_d       = 3'd0;
        line_j_d     = 1'b1;
        se0_d        = 1'b0;
      end
    end else begin
      cyc_d = bit_end ? '0 : cyc_q + CW'(1);
      if (bit_end) begin
        if (ones_q == 3'd6) begin
          // Stuffed zero: toggles the line, does not advance the stream and
          // never reaches the CRC. Also taken when EOP is next.
          ones_d   = 3'd0;
          line_j_d = ~line_j_q;
        end else if ((state_q == S_SYNC) || (state_q == S_DATA) || (state_q == S_CRC)) begin
          ones_d    = raw_bit ? ones_q + 3'd1 : 3'd0;
          line_j_d  = raw_bit ? line_j_q : ~line_j_q;
          bit_idx_d = bit_idx_q + 4'd1;
          case (state_q)
            S_SYNC: begin
              if (bit_idx_q[2:0] == 3'd7) begin
                state_d   = S_DATA;
                bit_idx_d = 4'd0;
                word_d    = buffer_read_value;
                addr_d    = addr_q + 8'd1;
              end
            end
            S_DATA: begin
              if (byte_idx_q != 11'd0) begin
                crc_d = crc_step;
              end
              if (bit_idx_q[2:0] == 3'd7) begin
                bit_idx_d = 4'd0;
                if (byte_idx_q == last_byte_q) begin
                  state_d = append_crc_q ? S_CRC : S_EOP_SE0;
                end else begin
                  byte_idx_d = byte_idx_q + 11'd1;
                  // Next word was addressed a whole word-time ago, so its
                  // read data is long since valid.
                  if (byte_idx_q[1:0] == 2'd3) begin
                    word_d = buffer_read_value;
                    addr_d = addr_q + 8'd1;
                  end
                end
              end
            end
            S_CRC: begin
              crc_d = {1'b0, crc_q[15:1]};
              if (bit_idx_q == 4'd15) begin
                state_d   = S_EOP_SE0;
                bit_idx_d = 4'd0;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else if (state_q == S_EOP_SE0) begin
          se0_d     = 1'b1;
          ones_d    = 3'd0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q[0]) begin
            state_d   = S_EOP_J;
            bit_idx_d = 4'd0;
          end
        end else begin
          // S_EOP_J: first boundary drives J, second ends the packet.
          se0_d    = 1'b0;
          line_j_d = 1'b1;
          if (bit_idx_q[0]) begin
            state_d   = S_IDLE;
            bit_idx_d = 4'd0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      bit_idx_q    <= 4'd0;
      byte_idx_q   <= 11'd0;
      last_byte_q  <= 11'd0;
      append_crc_q <= 1'b0;
      addr_q       <= 8'd0;
      word_q       <= 32'd0;
      crc_q        <= 16'd0;
      ones_q       <= 3'd0;
      line_j_q     <= 1'b1;
      se0_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      last_byte_q  <= last_byte_d;
      append_crc_q <= append_crc_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      crc_q        <= crc_d;
      ones_q       <= ones_d;
      line_j_q     <= line_j_d;
      se0_q        <= se0_d;
      done_q       <= done_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign usb_output_enable = busy;
  assign usb_d_p_out       = ~busy | (line_j_q & ~se0_q);
  assign usb_d_n_out       = busy & ~line_j_q & ~se0_q;
  assign done              = done_q;
  assign buffer_address    = addr_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// tb/tb_usb_transmitter.sv - self-checking bench for usb_transmitter
module tb_usb_transmitter;

  localparam int BC = 4;
  localparam logic [4:0] IDLE_V = 5'b00010;  // {oe,busy,done,dp,dn}
  localparam logic [1:0] SYM_J = 2'b10;
  localparam logic [1:0] SYM_K = 2'b01;
  localparam logic [1:0] SYM_0 = 2'b00;

  logic        clk48 = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_word_address;
  logic [10:0] packet_length;
  logic        append_crc;
  logic [7:0]  buffer_address;
  logic [31:0] buffer_read_value;
  logic        usb_d_p_out;
  logic        usb_d_n_out;
  logic        usb_output_enable;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  logic [4:0]  exp_q[$];
  logic [1:0]  syms[$];
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  usb_transmitter #(.BIT_CYCLES(BC)) dut (
    .clk48(clk48), .reset(reset), .start(start),
    .start_word_address(start_word_address), .packet_length(packet_length),
    .append_crc(append_crc), .buffer_address(buffer_address),
    .buffer_read_value(buffer_read_value), .usb_d_p_out(usb_d_p_out),
    .usb_d_n_out(usb_d_n_out), .usb_output_enable(usb_output_enable),
    .busy(busy), .done(done)
  );

  always #5 clk48 = ~clk48;

  always @(posedge clk48) buffer_read_value <= mem[buffer_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_s(input string name, input string act, input string req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%s required=%s", name, act, req);
    end
  endtask

  // Line symbols per bit time, from the packet rules: lead-in J, SYNC,
  // bytes LSB first, CRC (MSB-first non-reflected register, sent as
  // complement highest-degree first), stuffing, NRZI, then SE0 SE0 J.
  task automatic build_syms(input logic [7:0] sa, input int len, input bit ac);
    bit          raw[$];
    bit          st[$];
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] c;
    bit          top;
    int          ones;
    bit          j;
    syms.delete();
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    c = 16'hFFFF;
    for (int n = 0; n < len; n++) begin
      w = mem[8'(sa + 8'(n / 4))] >> (8 * (n % 4));
      b = w[7:0];
      for (int i = 0; i < 8; i++) begin
        raw.push_back(b[i]);
        if (n > 0) begin
          top = c[15] ^ b[i];
          c = {c[14:0], 1'b0};
          if (top) c = c ^ 16'h8005;
        end
      end
    end
    if (ac) for (int i = 15; i >= 0; i--) raw.push_back(!c[i]);
    ones = 0;
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      if (raw[i]) ones++; else ones = 0;
      if (ones == 6) begin
        st.push_back(1'b0);
        ones = 0;
      end
    end
    j = 1'b1;
    syms.push_back(SYM_J);
    foreach (st[i]) begin
      if (!st[i]) j = !j;
      syms.push_back(j ? SYM_J : SYM_K);
    end
    syms.push_back(SYM_0);
    syms.push_back(SYM_0);
    syms.push_back(SYM_J);
  endtask

  function automatic string sym_str();
    string s;
    s = "";
    foreach (syms[i]) begin
      if (syms[i] == SYM_J) s = {s, "J"};
      else if (syms[i] == SYM_K) s = {s, "K"};
      else s = {s, "0"};
    end
    return s;
  endfunction

  task automatic launch(input logic [7:0] sa, input int len, input bit ac);
    build_syms(sa, len, ac);
    @(posedge clk48); #1;
    start = 1'b1;
    start_word_address = sa;
    packet_length = 11'(len);
    append_crc = ac;
    exp_q.push_back(IDLE_V);
    foreach (syms[i]) repeat (BC) exp_q.push_back({3'b110, syms[i]});
    exp_q.push_back(5'b00110);
    @(posedge clk48); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() != 0) @(posedge clk48);
    repeat (3) @(posedge clk48);
  endtask

  task automatic compare_loop();
    logic [4:0] e;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk48);
      cyc++;
      if (chk_en) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = IDLE_V;
        check($sformatf("outputs_cycle_%0d", cyc),
              {27'd0, usb_output_enable, busy, done, usb_d_p_out, usb_d_n_out}, {27'd0, e});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] k;
      k = 8'(i);
      mem[i] = {k ^ 8'h5A, ~k, k + 8'd17, k * 8'd3};
    end
    reset = 1'b1;
    start = 1'b1;
    start_word_address = 8'h33;
    packet_length = 11'd5;
    append_crc = 1'b1;
    fork
      compare_loop();
    join_none

    // Reset held with start asserted
    @(posedge clk48); #1;
    chk_en = 1'b1;
    @(posedge clk48); #1;
    check("reset_outputs", {27'd0, usb_output_enable, busy, done, usb_d_p_out, usb_d_n_out}, 32'h02);
    check("reset_buffer_address", {24'd0, buffer_address}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(posedge clk48);

    // ACK
    mem[0] = 32'h000000D2;
    build_syms(8'd0, 1, 1'b0);
    check_s("ack_model", sym_str(), "JKJKJKJKKJJKJJKKK00J");
    check("ack_bit_times", syms.size(), 32'd20);
    launch(8'd0, 1, 1'b0);
    drain();

    // Stuffing inside a byte
    mem[0] = 32'h000000FF;
    build_syms(8'd0, 1, 1'b0);
    check_s("stuff_model", sym_str(), "JKJKJKJKKKKKKKJJJJ00J");
    launch(8'd0, 1, 1'b0);
    drain();

    // Stuffing as the last bit before EOP
    mem[0] = 32'h000000FC;
    build_syms(8'd0, 1, 1'b0);
    check_s("tail_stuff_model", sym_str(), "JKJKJKJKKJKKKKKKKJ00J");
    launch(8'd0, 1, 1'b0);
    drain();

    // Empty-payload CRC: sixteen raw zeros
    mem[0] = 32'h000000C3;
    build_syms(8'd0, 1, 1'b1);
    check_s("crc_model", sym_str(), "JKJKJKJKKKKJKJKKKJKJKJKJKJKJKJKJK00J");
    launch(8'd0, 1, 1'b1);
    drain();

    // Word crossing with address wrap, CRC over real data
    mem[255] = 32'h0302014B;
    mem[0]   = 32'h00000504;
    launch(8'd255, 6, 1'b1);
    drain();

    // Zero length is ignored
    @(posedge clk48); #1;
    start = 1'b1;
    packet_length = 11'd0;
    @(posedge clk48); #1;
    start = 1'b0;
    repeat (12) @(posedge clk48);

    // Longer packet across the wrap, with a start pulse during DATA
    launch(8'd250, 37, 1'b1);
    repeat (200) @(posedge clk48);
    #1;
    start = 1'b1;
    packet_length = 11'd3;
    start_word_address = 8'd7;
    @(posedge clk48); #1;
    start = 1'b0;
    drain();

    // Reset during DATA
    launch(8'd10, 8, 1'b1);
    repeat (120) @(posedge clk48);
    #1;
    reset = 1'b1;
    while (exp_q.size() > 1) exp_q.pop_back();
    @(posedge clk48); #1;
    reset = 1'b0;
    check("abort_buffer_address", {24'd0, buffer_address}, 32'd0);
    check("abort_outputs", {27'd0, usb_output_enable, busy, done, usb_d_p_out, usb_d_n_out}, 32'h02);
    drain();
    repeat (20) @(posedge clk48);

    // Transmitter still usable after abort
    mem[0] = 32'h000000D2;
    launch(8'd0, 1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_transmitter.md
USB_TRANSMITTER -- requirements
Module: usb_transmitter

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, meaning clk48 cycles per USB full-speed bit (48 MHz / 12 Mbit/s).
REQ-002 SHALL have ports, clock and reset first:
  clk48  input  1  sole clock; all logic on posedge.
  reset  input  1  synchronous, active-high reset.
  start  input  1  one-cycle request to transmit a packet; sampled only in IDLE.
  start_word_address  input  8  packet buffer word index holding byte 0; sampled with start.
  packet_length  input  11  byte count, 0..1024; sampled with start.
  append_crc  input  1  when 1, CRC16 is appended after the last byte; sampled with start.
  buffer_address  output  8  packet buffer word index being read.
  buffer_read_value  input  32  word at buffer_address, valid one clk48 after the address is presented.
  usb_d_p_out  output  1  D+ drive value.
  usb_d_n_out  output  1  D- drive value.
  usb_output_enable  output  1  1 while driving the bus.
  busy  output  1  1 from accepted start until done.
  done  output  1  one-cycle pulse when the packet is finished.

Function
REQ-003 SHALL implement states IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J: IDLE->SYNC on accepted start; SYNC->DATA after 8 raw bits; DATA->CRC after the last byte if append_crc=1, otherwise DATA->EOP_SE0; CRC->EOP_SE0 after 16 raw bits; EOP_SE0->EOP_J after 2 bit times; EOP_J->IDLE after 1 bit time.
REQ-004 SHALL accept start only in IDLE with packet_length != 0; start while busy, or with length 0, SHALL be ignored with no done pulse.
REQ-005 SHALL assert busy and usb_output_enable on the cycle after an accepted start, driving J (D+=1, D-=0) for exactly 1 bit time before the first sync bit.
REQ-006 SHALL hold each line state for exactly BIT_CYCLES clk48 cycles.
REQ-007 SHALL take byte n from word start_word_address + (n >> 2), at bits [8*(n mod 4)+7 : 8*(n mod 4)]; the word index SHALL wrap modulo 256.
REQ-008 SHALL present each word address at least 2 cycles before its first bit is needed, so that the one-cycle read latency never stalls the bit stream.
REQ-009 SHALL transmit every byte LSB first; SYNC SHALL be the raw byte 0x80 (raw bits 0000000 then 1).
REQ-010 SHALL NRZI-encode the raw stream: a raw 0 toggles between J and K, a raw 1 holds the line; K is D+=0, D-=1; the line state before SYNC is J.
REQ-011 SHALL insert a raw 0 (bit stuff) after every 6 consecutive raw 1s across SYNC, DATA and CRC.
  - The ones counter SHALL reset to 0 at the start of SYNC, after each stuffed bit, and on each raw 0.
  - A stuff bit SHALL be inserted even when the sixth 1 is the final bit before EOP.
REQ-012 CRC16 rules:
  - polynomial x^16+x^15+x^2+1, initial value 0xFFFF;
  - computed over raw bytes 1..packet_length-1 (byte 0 is the PID), LSB-first;
  - transmitted as the ones-complement, bit 0 first;
  - stuffed bits SHALL NOT enter the CRC.
REQ-013 SHALL drive SE0 (D+=0, D-=0) for 2 bit times, then J for 1 bit time.
REQ-014 On the cycle after the J bit time ends, SHALL deassert usb_output_enable and busy, pulse done for 1 cycle, and enter IDLE.
REQ-015 While not driving, SHALL hold usb_d_p_out=1 and usb_d_n_out=0.

Reset
REQ-016 On reset=1 at a clock edge, SHALL enter IDLE with usb_output_enable=0, busy=0, done=0, usb_d_p_out=1, usb_d_n_out=0, buffer_address=0, and the ones counter and CRC cleared.
REQ-017 Reset mid-packet SHALL abort immediately with no EOP and no done pulse; reset SHALL take priority over start in the same cycle.

Verification
REQ-018 Reset: assert reset for 2 cycles while start=1 -> outputs match REQ-016, no transmission.
REQ-019 ACK: buffer word 0 = 0x000000D2, start_word_address=0, length=1, append_crc=0 -> J, then KJKJKJKK, then JJKJJKKK, then SE0, SE0, J (20 bit times = 80 clk48 cycles), then done pulse.
REQ-020 Bit stuffing: byte 0 = 0xFF, length=1, append_crc=0 -> sync's final 1 plus five 1s, then a stuffed 0 (line toggles), then 3 more 1s; 8+9 raw bit times before EOP.
REQ-021 CRC: byte 0 = 0xC3, length=1, append_crc=1 -> CRC field is sixteen raw 0s (complement of 0xFFFF), each toggling the line.
REQ-022 Word crossing and wrap: start_word_address=255, length=6, bytes 0x4B,1,2,3,4,5 -> bytes 0..3 read from word 255, bytes 4..5 from word 0, transmitted in order with no gap.
REQ-023 Robustness: a start pulse during DATA is ignored (single done pulse only); reset during DATA -> usb_output_enable=0 on the next cycle and no done pulse.
